// File: rtl/mux_n_pipe_pkg.sv
// Shared definitions for the N:1 registered select: select-encoding constants and
// the select-width derivation used by every module in this slice.
package mux_n_pipe_pkg;

  localparam int SEL_BINARY = 0;
  localparam int SEL_ONEHOT = 1;

  function automatic int sel_width(input int num_in, input int onehot);
    return (onehot == SEL_ONEHOT) ? num_in : $clog2(num_in);
  endfunction

endpackage

// File: rtl/mux_n_pipe_sel.sv
// Combinational N:1 select with illegal-select detect. An illegal select yields a
// zero word with err set, so downstream never sees a stale or OR-merged operand.
module mux_n_pipe_sel
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int ONEHOT = SEL_BINARY,
  localparam int SEL_W = sel_width(NUM_IN, ONEHOT)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        word,
  output logic                    err
);

  if (ONEHOT == SEL_ONEHOT) begin : g_onehot
    always_comb begin
      word = '0;
      err  = ($countones(sel) != 1);
      if (!err) begin
        for (int k = 0; k < NUM_IN; k++) begin
          if (sel[k]) word = in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end else begin : g_binary
    // Codes at or above NUM_IN match no input and fall through to the error default.
    always_comb begin
      word = '0;
      err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
        if (sel == SEL_W'(k)) begin
          word = in_data[k*WIDTH +: WIDTH];
          err  = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// N:1 operand select feeding a registered output stage with valid/ready handshake,
// a one-entry skid buffer for back-pressure, and flush.
module mux_n_pipe
  import mux_n_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int ONEHOT = SEL_BINARY,
  localparam int SEL_W = sel_width(NUM_IN, ONEHOT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] word_p0;
  logic             err_p0;
  logic [WIDTH-1:0] data_p1;
  logic             err_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] skid_data_p1;
  logic             skid_err_p1;
  logic             skid_vld_p1;
  logic             accept;
  logic             out_free;

  mux_n_pipe_sel #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .ONEHOT (ONEHOT)
  ) u_sel (
    .in_data (in_data),
    .sel     (sel),
    .word    (word_p0),
    .err     (err_p0)
  );

  // A full skid means OUT is blocked behind it, so no new word can be taken.
  assign in_ready = !skid_vld_p1 && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign out_free = !vld_p1 || out_ready;

  // ---- stage p0 -> p1: occupancy control ----
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (skid_vld_p1) begin
      if (out_ready) skid_vld_p1 <= 1'b0;
    end else if (accept) begin
      if (out_free) vld_p1      <= 1'b1;
      else          skid_vld_p1 <= 1'b1;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // ---- stage p0 -> p1: output register (held across flush, cleared by reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      err_p1  <= 1'b0;
    end else if (!flush) begin
      if (skid_vld_p1) begin
        if (out_ready) begin
          data_p1 <= skid_data_p1;
          err_p1  <= skid_err_p1;
        end
      end else if (accept && out_free) begin
        data_p1 <= word_p0;
        err_p1  <= err_p0;
      end
    end
  end

  // ---- stage p0 -> p1: skid register, only loaded while OUT is stalled ----
  always_ff @(posedge clk) begin
    if (accept && !out_free) begin
      skid_data_p1 <= word_p0;
      skid_err_p1  <= err_p0;
    end
  end

  assign out_data  = data_p1;
  assign out_err   = err_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: three instances (4-in binary, 3-in binary, 4-in one-hot) share
// handshake stimulus and are compared against a two-deep FIFO reference model.
module tb_mux_n_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] w [4];
  logic [1:0]  sel4, sel3;
  logic [3:0]  seloh;
  logic [127:0] in_data4;
  logic [95:0]  in_data3;
  assign in_data4 = {w[3], w[2], w[1], w[0]};
  assign in_data3 = {w[2], w[1], w[0]};

  logic        rdy4, rdy3, rdyh, v4, v3, vh, e4, e3, eh;
  logic [31:0] d4, d3, dh;

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .ONEHOT(0)) u_bin4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel4), .in_valid(in_valid),
    .in_ready(rdy4), .flush(flush), .out_data(d4), .out_err(e4), .out_valid(v4),
    .out_ready(out_ready));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .ONEHOT(0)) u_bin3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel3), .in_valid(in_valid),
    .in_ready(rdy3), .flush(flush), .out_data(d3), .out_err(e3), .out_valid(v3),
    .out_ready(out_ready));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(4), .ONEHOT(1)) u_oh4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(seloh), .in_valid(in_valid),
    .in_ready(rdyh), .flush(flush), .out_data(dh), .out_err(eh), .out_valid(vh),
    .out_ready(out_ready));

  typedef struct {
    logic [31:0] d4, d3, dh;
    logic        e4, e3, eh;
  } ent_t;

  ent_t        q[$];
  ent_t        disp;
  logic [31:0] delivered[$];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t mk();
    ent_t x;
    x.d4 = w[sel4];
    x.e4 = 1'b0;
    if (sel3 < 2'd3) begin x.d3 = w[sel3]; x.e3 = 1'b0; end
    else             begin x.d3 = '0;      x.e3 = 1'b1; end
    if ($countones(seloh) == 1) begin x.dh = w[$clog2(seloh)]; x.eh = 1'b0; end
    else                        begin x.dh = '0;               x.eh = 1'b1; end
    return x;
  endfunction

  // One clock: check ready against the model, advance the model, then check outputs.
  task automatic step();
    logic exp_rdy;
    #1;
    exp_rdy = (q.size() < 2) && !flush && !rst;
    chk("in_ready4", rdy4, exp_rdy);
    chk("in_ready3", rdy3, exp_rdy);
    chk("in_readyh", rdyh, exp_rdy);
    if (v4 && out_ready) delivered.push_back(d4);
    if (rst) begin
      q.delete();
      disp = '{default: '0};
    end else if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back(mk());
      if (q.size() > 0) disp = q[0];
    end
    @(posedge clk);
    #1;
    chk("out_valid4", v4, q.size() > 0);
    chk("out_valid3", v3, q.size() > 0);
    chk("out_validh", vh, q.size() > 0);
    chk("out_data4", d4, disp.d4);
    chk("out_err4",  e4, disp.e4);
    chk("out_data3", d3, disp.d3);
    chk("out_err3",  e3, disp.e3);
    chk("out_datah", dh, disp.dh);
    chk("out_errh",  eh, disp.eh);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel4 = '0; sel3 = '0; seloh = 4'b0001;
    for (int k = 0; k < 4; k++) w[k] = '0;
    disp = '{default: '0};
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_vld", v4, 0);
    chk("rst_data", d4, 0);
    chk("rst_err", e4, 0);

    // Plain select, 1-cycle latency
    for (int k = 0; k < 4; k++) w[k] = 32'h1000 + k;
    sel4 = 2'd2; sel3 = 2'd2; seloh = 4'b0100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_data", d4, 32'h1002);
    chk("t1_vld", v4, 1);
    chk("t1_err", e4, 0);
    chk("t1_datah", dh, 32'h1002);
    step();

    // Illegal selects
    sel4 = 2'd1; sel3 = 2'd3; seloh = 4'b0110; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_data3", d3, 0);
    chk("t2_err3", e3, 1);
    chk("t2_datah", dh, 0);
    chk("t2_errh", eh, 1);
    chk("t2_data4", d4, 32'h1001);
    step();

    // Back-pressure: A, B, C in order through the skid
    delivered.delete();
    sel4 = 2'd0; sel3 = 2'd0; seloh = 4'b0001;
    w[0] = 32'hA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0; w[0] = 32'hB;
    step();
    chk("t3_rdy_low", rdy4, 0);
    w[0] = 32'hC;
    step(); step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    step(); step();
    chk("t3_count", delivered.size(), 3);
    if (delivered.size() == 3) begin
      chk("t3_first", delivered[0], 32'hA);
      chk("t3_second", delivered[1], 32'hB);
      chk("t3_third", delivered[2], 32'hC);
    end

    // Flush with OUT and SKID full and input presented
    out_ready = 1'b0; in_valid = 1'b1; w[0] = 32'h11;
    step();
    w[0] = 32'h22;
    step();
    w[0] = 32'h33; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("t4_vld", v4, 0);
    chk("t4_rdy", rdy4, 1);
    chk("t4_hold", d4, 32'h11);
    step();
    chk("t4_vld2", v4, 0);

    // Reset mid-stream
    in_valid = 1'b1; w[0] = 32'h55; sel3 = 2'd3;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("t5_vld", v4, 0);
    chk("t5_data", d4, 0);
    chk("t5_err3", e3, 0);
    chk("t5_rdy", rdy4, 1);

    // Full throughput with select cycling
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      sel4 = 2'(i % 4); sel3 = 2'(i % 4); seloh = 4'(1 << (i % 4));
      step();
      chk("t6_rdy", rdy4, 1);
      chk("t6_vld", v4, 1);
    end
    in_valid = 1'b0;
    step();

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 4; k++) w[k] = $urandom;
      sel4 = 2'($urandom_range(0, 3));
      sel3 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) seloh = 4'(1 << $urandom_range(0, 3));
      else                           seloh = 4'($urandom_range(0, 15));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 5);
      rst       = ($urandom_range(0, 99) < 2);
      step();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
